// File: rtl/seven_seg_scan_ctrl_if.sv
// Purpose: bundles the display controller's value/strobe inputs and pin outputs.
// Latency: none, wiring only.
// Backpressure: the controller reports busy and drops loads while it is high.
interface seven_seg_scan_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dataIn;
    logic              load;
    logic              mode;
    logic              blank_lz;
    logic              busy;
    logic [DIGITS-1:0] anode;
    logic [7:0]        sevenSeg;

    // Stimulus / board side drives the value and strobes
    modport master (
        output dataIn, load, mode, blank_lz,
        input  busy, anode, sevenSeg
    );

    // Display controller side
    modport slave (
        input  dataIn, load, mode, blank_lz,
        output busy, anode, sevenSeg
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Purpose: multi-digit seven-segment scanner showing a latched value in hex or decimal.
// Latency: hex value visible one cycle after load; decimal after DATA_W conversion cycles + 1.
// Backpressure: busy is high during a decimal conversion; loads arriving then are dropped.
module seven_seg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_scan_ctrl_if.slave  bus
);

    localparam int BW     = 4 * DIGITS;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int STEP_W = $clog2(DATA_W + 1);
    localparam logic [39:0] DEC_LIMIT = 40'(10 ** DIGITS);

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_refresh_cnt;
    logic [IDX_W-1:0]   r_digit_idx;
    logic [BW-1:0]      r_disp;
    logic               r_ovf;
    logic [DATA_W-1:0]  r_shift;
    logic [BW-1:0]      r_bcd;
    logic [STEP_W-1:0]  r_step;
    logic               r_ovf_pend;
    logic [DIGITS-1:0]  r_anode;
    logic [7:0]         r_seg;

    logic [BW+DATA_W-1:0] w_ext;
    logic               w_hex_ovf;
    logic               w_dec_ovf;
    logic               w_step_done;
    logic [BW-1:0]      w_bcd_adj;
    logic [BW-1:0]      w_bcd_nxt;
    logic [3:0]         w_nibble;
    logic               w_blank;
    logic [7:0]         w_seg_nxt;
    logic [DIGITS-1:0]  w_anode_nxt;

    function automatic logic [7:0] f_glyph(input logic [3:0] n);
        case (n)
            4'h0:    f_glyph = 8'hC0;
            4'h1:    f_glyph = 8'hF9;
            4'h2:    f_glyph = 8'hA4;
            4'h3:    f_glyph = 8'hB0;
            4'h4:    f_glyph = 8'h99;
            4'h5:    f_glyph = 8'h92;
            4'h6:    f_glyph = 8'h82;
            4'h7:    f_glyph = 8'hF8;
            4'h8:    f_glyph = 8'h80;
            4'h9:    f_glyph = 8'h90;
            4'hA:    f_glyph = 8'h88;
            4'hB:    f_glyph = 8'h83;
            4'hC:    f_glyph = 8'hC6;
            4'hD:    f_glyph = 8'hA1;
            4'hE:    f_glyph = 8'h86;
            4'hF:    f_glyph = 8'h8E;
            default: f_glyph = 8'hFF;
        endcase
    endfunction

    // Zero-extending dataIn lets the bits above the display width flag hex overflow
    assign w_ext       = {{BW{1'b0}}, bus.dataIn};
    assign w_hex_ovf   = |w_ext[BW+DATA_W-1:BW];
    assign w_dec_ovf   = (40'(bus.dataIn) >= DEC_LIMIT);
    assign w_step_done = (r_step == STEP_W'(DATA_W - 1));
    assign bus.busy    = (r_state == ST_CONV);

    // Double-dabble: add 3 to any BCD nibble >= 5, then shift the next binary bit in.
    // Only the low DIGITS decimal digits are kept; higher digits never feed back down.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
        w_bcd_nxt = {w_bcd_adj[BW-2:0], r_shift[DATA_W-1]};
    end

    // Conversion FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Conversion FSM next state: idle until a decimal load, convert for DATA_W cycles
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.load && bus.mode) w_state_nxt = ST_CONV;
            ST_CONV: if (w_step_done)          w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    // Display register and converter datapath; the display only changes on a finished value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp     <= '0;
            r_ovf      <= 1'b0;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_step     <= '0;
            r_ovf_pend <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (bus.load && bus.mode) begin
                r_shift    <= bus.dataIn;
                r_bcd      <= '0;
                r_step     <= '0;
                r_ovf_pend <= w_dec_ovf;
            end else if (bus.load) begin
                r_disp <= w_ext[BW-1:0];
                r_ovf  <= w_hex_ovf;
            end
        end else begin
            r_shift <= r_shift << 1;
            r_bcd   <= w_bcd_nxt;
            r_step  <= r_step + 1'b1;
            if (w_step_done) begin
                r_disp <= w_bcd_nxt;
                r_ovf  <= r_ovf_pend;
            end
        end
    end

    // Refresh timer and digit index; each digit stays selected for REFRESH_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= '0;
        end else if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_refresh_cnt <= '0;
            if (r_digit_idx == IDX_W'(DIGITS - 1)) begin
                r_digit_idx <= '0;
            end else begin
                r_digit_idx <= r_digit_idx + 1'b1;
            end
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // Select the current digit's nibble and decide whether it is a leading zero
    always_comb begin
        logic v_zero_above;
        v_zero_above = 1'b1;
        w_nibble     = '0;
        w_blank      = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v_zero_above = v_zero_above & (r_disp[4*k +: 4] == 4'd0);
            if (r_digit_idx == IDX_W'(k)) begin
                w_nibble = r_disp[4*k +: 4];
                w_blank  = v_zero_above && (k != 0);
            end
        end
    end

    // Overflow dashes win over blanking; digit 0 is never blanked
    always_comb begin
        w_anode_nxt = ~(DIGITS'(1) << r_digit_idx);
        if (r_ovf) begin
            w_seg_nxt = 8'hBF;
        end else if (bus.blank_lz && w_blank) begin
            w_seg_nxt = 8'hFF;
        end else begin
            w_seg_nxt = f_glyph(w_nibble);
        end
    end

    // Registered pin outputs, all segments and anodes off in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_anode <= '1;
            r_seg   <= 8'hFF;
        end else begin
            r_anode <= w_anode_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign bus.anode    = r_anode;
    assign bus.sevenSeg = r_seg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: three instances (4, 2 and 1 digits) share the stimulus
// and are compared every cycle with an arithmetic model of the displayed number.
module tb_seven_seg_scan_ctrl;

    localparam int RD = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Model state: shown value/mode, pending decimal value, busy countdown, scan edge count
    int   sc;
    int   d_val;
    bit   d_dec;
    int   p_val;
    int   m_busy;

    int   DIGS [3] = '{4, 2, 1};
    logic [7:0] GLY [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] AN_SEQ [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    seven_seg_scan_ctrl_if #(.DIGITS(4), .DATA_W(8)) if4 ();
    seven_seg_scan_ctrl_if #(.DIGITS(2), .DATA_W(8)) if2 ();
    seven_seg_scan_ctrl_if #(.DIGITS(1), .DATA_W(8)) if1 ();

    seven_seg_scan_ctrl #(.DIGITS(4), .DATA_W(8), .REFRESH_DIV(RD)) u4 (.clk(clk), .rst(rst), .bus(if4));
    seven_seg_scan_ctrl #(.DIGITS(2), .DATA_W(8), .REFRESH_DIV(RD)) u2 (.clk(clk), .rst(rst), .bus(if2));
    seven_seg_scan_ctrl #(.DIGITS(1), .DATA_W(8), .REFRESH_DIV(RD)) u1 (.clk(clk), .rst(rst), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] get_an(int d);
        case (d)
            0:       return {4'hF, if4.anode};
            1:       return {6'h3F, if2.anode};
            default: return {7'h7F, if1.anode};
        endcase
    endfunction

    function automatic logic [7:0] get_seg(int d);
        case (d)
            0:       return if4.sevenSeg;
            1:       return if2.sevenSeg;
            default: return if1.sevenSeg;
        endcase
    endfunction

    function automatic logic get_busy(int d);
        case (d)
            0:       return if4.busy;
            1:       return if2.busy;
            default: return if1.busy;
        endcase
    endfunction

    // Expected glyph of digit idx for a display of dig digits showing val
    function automatic logic [7:0] exp_seg(int dig, int idx, int val, bit dec, bit blank);
        int base;
        int pw;
        int lim;
        base = dec ? 10 : 16;
        pw   = 1;
        lim  = 1;
        for (int i = 0; i < idx; i++) pw = pw * base;
        for (int i = 0; i < dig; i++) lim = lim * base;
        if (val >= lim) return 8'hBF;
        if (blank && idx > 0 && val < pw) return 8'hFF;
        return GLY[(val / pw) % base];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(int v, bit md, bit ld, bit bl);
        if4.dataIn = 8'(v);   if2.dataIn = 8'(v);   if1.dataIn = 8'(v);
        if4.mode = md;        if2.mode = md;        if1.mode = md;
        if4.load = ld;        if2.load = ld;        if1.load = ld;
        if4.blank_lz = bl;    if2.blank_lz = bl;    if1.blank_lz = bl;
    endtask

    // One clock: predict outputs from the pre-edge model, advance the model, compare all DUTs
    task automatic tick();
        bit         r, l, md, b;
        int         v, idx;
        logic [7:0] ea [3];
        logic [7:0] es [3];
        r  = rst;
        l  = if4.load;
        md = if4.mode;
        b  = if4.blank_lz;
        v  = int'(if4.dataIn);
        for (int d = 0; d < 3; d++) begin
            if (r) begin
                ea[d] = 8'hFF;
                es[d] = 8'hFF;
            end else begin
                idx   = (sc / RD) % DIGS[d];
                ea[d] = ~(8'(1) << idx);
                es[d] = exp_seg(DIGS[d], idx, d_val, d_dec, b);
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            sc = 0; d_val = 0; d_dec = 0; m_busy = 0;
        end else begin
            sc++;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    d_val = p_val;
                    d_dec = 1'b1;
                end
            end else if (l) begin
                if (md) begin
                    p_val  = v;
                    m_busy = 8;
                end else begin
                    d_val = v;
                    d_dec = 1'b0;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("anode[d%0d]", DIGS[d]), 32'(get_an(d)), 32'(ea[d]));
            chk($sformatf("seg[d%0d]", DIGS[d]), 32'(get_seg(d)), 32'(es[d]));
            chk($sformatf("busy[d%0d]", DIGS[d]), 32'(get_busy(d)), 32'(m_busy > 0));
        end
    endtask

    // Walk the scan and compare each digit with a literal glyph (byte k = digit k)
    task automatic check_lit(int d, logic [31:0] e, string tag);
        int waited;
        for (int k = 0; k < DIGS[d]; k++) begin
            waited = 0;
            while (get_an(d) != ~(8'(1) << k) && waited < 40) begin
                tick();
                waited++;
            end
            chk($sformatf("%s wait digit%0d", tag, k), 32'(waited < 40), 32'd1);
            chk($sformatf("%s digit%0d", tag, k), 32'(get_seg(d)), 32'(e[8*k +: 8]));
        end
    endtask

    // Count cycles until busy drops, starting from the count already seen
    task automatic wait_busy(int start, string tag);
        int bc;
        bc = start;
        while (if4.busy && bc < 40) begin
            tick();
            bc++;
        end
        chk(tag, 32'(bc), 32'd8);
    endtask

    initial begin
        int v, n;
        bit md, bl;
        checks = 0; errors = 0;
        sc = 0; d_val = 0; d_dec = 0; p_val = 0; m_busy = 0;
        rst = 1'b1;
        set_in(0, 0, 0, 0);

        // 1: reset then plain scan of zero
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((i - 1) % 4 == 0) chk("scan anode seq", 32'(if4.anode), 32'(AN_SEQ[(i - 1) / 4]));
            chk("scan seg zero", 32'(if4.sevenSeg), 32'hC0);
        end

        // 2: hex A5, then with blanking
        set_in(8'hA5, 0, 1, 0); tick(); set_in(8'hA5, 0, 0, 0); tick();
        check_lit(0, 32'hC0C0_8892, "hexA5");
        set_in(8'hA5, 0, 0, 1); tick();
        check_lit(0, 32'hFFFF_8892, "hexA5 blank");
        set_in(8'hA5, 0, 0, 0);

        // 3: decimal 255
        set_in(255, 1, 1, 0); tick(); set_in(255, 1, 0, 0);
        wait_busy(0, "busy len 255");
        tick();
        check_lit(0, 32'hC0A4_9292, "dec255");

        // 4: decimal 200 with an ignored second load
        set_in(200, 1, 1, 0); tick();
        set_in(7, 0, 1, 0); tick(); set_in(7, 0, 0, 0);
        wait_busy(1, "busy len 200");
        tick();
        check_lit(0, 32'hC0A4_C0C0, "dec200");
        set_in(200, 1, 1, 0); tick(); set_in(200, 1, 0, 0);
        tick(); tick();
        rst = 1'b1; tick();
        chk("busy after mid rst", 32'(if4.busy), 32'd0);
        rst = 1'b0; tick();
        check_lit(0, 32'hC0C0_C0C0, "after mid rst");

        // 5: small displays overflow
        set_in(100, 1, 1, 0); tick(); set_in(100, 1, 0, 0);
        wait_busy(0, "busy len 100");
        tick();
        check_lit(1, 32'h0000_BFBF, "d2 dec100");
        set_in(8'h1F, 0, 1, 0); tick(); set_in(8'h1F, 0, 0, 0); tick();
        check_lit(2, 32'h0000_00BF, "d1 hex1F");
        set_in(8'h0F, 0, 1, 0); tick(); set_in(8'h0F, 0, 0, 0); tick();
        check_lit(2, 32'h0000_008E, "d1 hex0F");

        // 6: zero with blanking, then reset beating a simultaneous load
        set_in(0, 0, 1, 1); tick(); set_in(0, 0, 0, 1); tick();
        check_lit(0, 32'hFFFF_FFC0, "zero blank");
        set_in(8'h3C, 0, 1, 0); tick(); set_in(8'h3C, 0, 0, 0); tick();
        rst = 1'b1; set_in(8'h55, 0, 1, 0); tick();
        rst = 1'b0; set_in(8'h55, 0, 0, 0); tick();
        check_lit(0, 32'hC0C0_C0C0, "rst wins load");

        // Random loads, modes, blanking and loads while busy
        for (int it = 0; it < 40; it++) begin
            v  = $urandom_range(0, 255);
            md = 1'($urandom % 2);
            bl = 1'($urandom % 2);
            set_in(v, md, 1, bl); tick(); set_in(v, md, 0, bl);
            n = $urandom_range(0, 14);
            for (int j = 0; j < n; j++) begin
                if ($urandom % 4 == 0) set_in($urandom_range(0, 255), 1'($urandom % 2), 1, 1'($urandom % 2));
                tick();
                set_in(v, md, 0, bl);
            end
            repeat ($urandom_range(1, 10)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
